// File: rtl/clock_phase_ctrl_if.sv
// Control/status bundle between the bench clock driver and clock_phase_ctrl:
// halt/resume requests in, core reset, phase enables, halt status and group count out.
interface clock_phase_ctrl_if #(
    parameter int COUNT_W = 32
);
    logic               halt;
    logic               resume;
    logic               sys_rst_n;
    logic               imem_ce;
    logic               regfile_ce;
    logic               dmem_ce;
    logic               proc_ce;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output halt, resume,
        input  sys_rst_n, imem_ce, regfile_ce, dmem_ce, proc_ce, halted, instr_count
    );

    modport slave (
        input  halt, resume,
        output sys_rst_n, imem_ce, regfile_ce, dmem_ce, proc_ce, halted, instr_count
    );
endinterface

// File: rtl/clock_phase_ctrl.sv
// Reset synchronizer, core-reset hold and four-phase clock-enable sequencer for
// the single-cycle MIPS skeleton, with halt/resume and a completed-group counter.
module clock_phase_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int COUNT_W     = 32
) (
    input  logic                clock,
    input  logic                reset,
    clock_phase_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic               sync_ff1;
    logic               sync_n;
    logic [1:0]         state;
    logic [7:0]         hold_cnt;
    logic [1:0]         phase;
    logic               halt_pending;
    logic               sys_rst_n_q;
    logic               halted_q;
    logic [COUNT_W-1:0] instr_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff1 <= 1'b0;
            sync_n   <= 1'b0;
        end else begin
            sync_ff1 <= 1'b1;
            sync_n   <= sync_ff1;
        end
    end

    // A group always runs to its phase-3 commit; halt requests are parked until then.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_HOLD;
            hold_cnt      <= 8'd0;
            phase         <= 2'd0;
            halt_pending  <= 1'b0;
            sys_rst_n_q   <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (sync_n) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state       <= ST_RUN;
                            sys_rst_n_q <= 1'b1;
                            phase       <= 2'd0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        instr_count_q <= instr_count_q + COUNT_W'(1);
                        if (halt_pending || bus.halt) begin
                            state        <= ST_HALTED;
                            phase        <= 2'd0;
                            halt_pending <= 1'b0;
                            halted_q     <= 1'b1;
                        end
                    end else if (bus.halt) begin
                        halt_pending <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state    <= ST_RUN;
                        phase    <= 2'd0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.imem_ce     = (state == ST_RUN) && (phase == 2'd0);
    assign bus.regfile_ce  = (state == ST_RUN) && (phase == 2'd1);
    assign bus.dmem_ce     = (state == ST_RUN) && (phase == 2'd2);
    assign bus.proc_ce     = (state == ST_RUN) && (phase == 2'd3);
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = instr_count_q;
endmodule
